// File: rtl/udp_tx_arbiter_if.sv
// MAC-side transmit handshake between the arbiter and mac_top.
// master = arbiter (request, length, id, data), slave = mac_top.
interface udp_tx_arbiter_if;
  logic        mac_ready;
  logic        mac_fifo_rd_en;
  logic [7:0]  mac_fifo_data;
  logic        mac_send_end;
  logic        udp_tx_req;
  logic [15:0] udp_send_data_length;
  logic [15:0] identify_code;

  modport master (
    input  mac_ready,
    input  mac_fifo_rd_en,
    input  mac_send_end,
    output mac_fifo_data,
    output udp_tx_req,
    output udp_send_data_length,
    output identify_code
  );

  modport slave (
    output mac_ready,
    output mac_fifo_rd_en,
    output mac_send_end,
    input  mac_fifo_data,
    input  udp_tx_req,
    input  udp_send_data_length,
    input  identify_code
  );
endinterface

// File: rtl/udp_tx_arbiter.sv
// Round-robin scheduler of two byte FIFOs onto the single UDP tx path.
// Ports: gmii_tx_clk/rst_n, mac (MAC handshake), chX_* FIFO side, status.
module udp_tx_arbiter #(
  parameter int CH0_LEN    = 1024,
  parameter int CH1_LEN    = 512,
  parameter int IFG_CYCLES = 16,
  parameter int TIMEOUT    = 125_000_000
) (
  input  logic        gmii_tx_clk,
  input  logic        rst_n,
  udp_tx_arbiter_if.master mac,
  input  logic        ch0_enable,
  input  logic        ch1_enable,
  input  logic [7:0]  ch0_fifo_data,
  input  logic [7:0]  ch1_fifo_data,
  input  logic [10:0] ch0_fifo_count,
  input  logic [10:0] ch1_fifo_count,
  output logic        ch0_fifo_rd_en,
  output logic        ch1_fifo_rd_en,
  output logic        active_ch,
  output logic        busy,
  output logic        len_err,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE, ARB, REQ, SEND, GAP
  } state_t;

  state_t state, state_n;

  logic [10:0] cnt0_q, cnt1_q;
  logic        last_grant;
  logic [14:0] seq0, seq1;
  logic [15:0] len_q, id_q, rd_cnt, gap_cnt;
  logic [31:0] wd;
  logic        elig0, elig1, grant, grant_ch;
  logic        wd_hit, gap_done, routed;

  assign elig0    = ch0_enable & (cnt0_q >= 11'(CH0_LEN));
  assign elig1    = ch1_enable & (cnt1_q >= 11'(CH1_LEN));
  assign grant    = elig0 | elig1;
  assign wd_hit   = (wd == 32'(TIMEOUT - 1));
  assign gap_done = (gap_cnt == 16'(IFG_CYCLES - 1));

  always_comb begin
    grant_ch = 1'b0;
    unique case (1'b1)
      elig0 & elig1:  grant_ch = ~last_grant;
      elig0 & ~elig1: grant_ch = 1'b0;
      ~elig0 & elig1: grant_ch = 1'b1;
      default:        grant_ch = 1'b0;
    endcase
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (mac.mac_ready) state_n = ARB;
      ARB: begin
        if (!mac.mac_ready) state_n = IDLE;
        else if (grant)     state_n = REQ;
      end
      REQ:  state_n = SEND;
      SEND: if (mac.mac_send_end || wd_hit) state_n = GAP;
      GAP:  if (gap_done) state_n = ARB;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    routed         = mac.mac_fifo_rd_en & (state == SEND);
    ch0_fifo_rd_en = routed & ~active_ch;
    ch1_fifo_rd_en = routed & active_ch;
    mac.udp_tx_req = (state == REQ);
    busy           = (state == REQ) | (state == SEND) | (state == GAP);
  end

  assign mac.mac_fifo_data        = active_ch ? ch1_fifo_data : ch0_fifo_data;
  assign mac.udp_send_data_length = len_q;
  assign mac.identify_code        = id_q;

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q      <= '0;
      cnt1_q      <= '0;
      last_grant  <= 1'b1;
      seq0        <= '0;
      seq1        <= '0;
      active_ch   <= 1'b0;
      len_q       <= '0;
      id_q        <= '0;
      rd_cnt      <= '0;
      wd          <= '0;
      gap_cnt     <= '0;
      len_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cnt0_q <= ch0_fifo_count;
      cnt1_q <= ch1_fifo_count;
      unique case (state)
        ARB: begin
          if (mac.mac_ready && grant) begin
            active_ch <= grant_ch;
            len_q     <= grant_ch ? 16'(CH1_LEN) : 16'(CH0_LEN);
            id_q      <= {grant_ch, grant_ch ? seq1 : seq0};
          end
        end
        REQ: begin
          rd_cnt <= '0;
          wd     <= '0;
        end
        SEND: begin
          if (routed) rd_cnt <= rd_cnt + 16'd1;
          wd      <= wd + 32'd1;
          gap_cnt <= '0;
          if (mac.mac_send_end) begin
            last_grant <= active_ch;
            if (active_ch) seq1 <= seq1 + 15'd1;
            else           seq0 <= seq0 + 15'd1;
            if (rd_cnt != len_q) len_err <= 1'b1;
          end else if (wd_hit) begin
            timeout_err <= 1'b1;
          end
        end
        GAP:     gap_cnt <= gap_cnt + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter with a behavioural MAC.
// Second instance (short watchdog) covers the timeout path.
module tb_udp_tx_arbiter;
  localparam int IFG = 16;
  localparam int TO  = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  logic        ch0_enable, ch1_enable;
  logic [7:0]  ch0_fifo_data, ch1_fifo_data;
  logic [10:0] ch0_fifo_count, ch1_fifo_count;
  logic        ch0_fifo_rd_en, ch1_fifo_rd_en;
  logic        active_ch, busy, len_err, timeout_err;
  logic        t_rd0, t_rd1, t_act, t_busy, t_len_err, t_to_err;

  udp_tx_arbiter_if bus ();
  udp_tx_arbiter_if bus2 ();

  udp_tx_arbiter dut (
    .gmii_tx_clk    (clk),
    .rst_n          (rst_n),
    .mac            (bus),
    .ch0_enable     (ch0_enable),
    .ch1_enable     (ch1_enable),
    .ch0_fifo_data  (ch0_fifo_data),
    .ch1_fifo_data  (ch1_fifo_data),
    .ch0_fifo_count (ch0_fifo_count),
    .ch1_fifo_count (ch1_fifo_count),
    .ch0_fifo_rd_en (ch0_fifo_rd_en),
    .ch1_fifo_rd_en (ch1_fifo_rd_en),
    .active_ch      (active_ch),
    .busy           (busy),
    .len_err        (len_err),
    .timeout_err    (timeout_err)
  );

  udp_tx_arbiter #(.TIMEOUT(TO)) dut_to (
    .gmii_tx_clk    (clk),
    .rst_n          (rst_n),
    .mac            (bus2),
    .ch0_enable     (ch0_enable),
    .ch1_enable     (ch1_enable),
    .ch0_fifo_data  (ch0_fifo_data),
    .ch1_fifo_data  (ch1_fifo_data),
    .ch0_fifo_count (ch0_fifo_count),
    .ch1_fifo_count (ch1_fifo_count),
    .ch0_fifo_rd_en (t_rd0),
    .ch1_fifo_rd_en (t_rd1),
    .active_ch      (t_act),
    .busy           (t_busy),
    .len_err        (t_len_err),
    .timeout_err    (t_to_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] r_len, r_id;
  logic        r_ch;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n               = 1'b0;
    bus.mac_ready       = 1'b0;
    bus.mac_fifo_rd_en  = 1'b0;
    bus.mac_send_end    = 1'b0;
    bus2.mac_ready      = 1'b0;
    bus2.mac_fifo_rd_en = 1'b0;
    bus2.mac_send_end   = 1'b0;
    ch0_enable          = 1'b0;
    ch1_enable          = 1'b0;
    ch0_fifo_count      = '0;
    ch1_fifo_count      = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_req(input string tag, output int w);
    logic seen;
    seen = 1'b0;
    w = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      w++;
      if (bus.udp_tx_req) seen = 1'b1;
    end
    chk({tag, "_req"}, 32'(seen), 32'd1);
    r_len = bus.udp_send_data_length;
    r_id  = bus.identify_code;
    r_ch  = active_ch;
  endtask

  task automatic send_pkt(input int n, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      bus.mac_fifo_rd_en = 1'b1;
      #1;
      c0 += int'(ch0_fifo_rd_en);
      c1 += int'(ch1_fifo_rd_en);
      if (i == 0)
        chk("data_mux", 32'(bus.mac_fifo_data),
            r_ch ? 32'h5A : 32'hA5);
      @(negedge clk);
    end
    bus.mac_fifo_rd_en = 1'b0;
    bus.mac_send_end   = 1'b1;
    @(negedge clk);
    bus.mac_send_end   = 1'b0;
  endtask

  logic [15:0] e_id [4];
  logic [15:0] e_len [4];
  logic        e_ch [4];
  int w, c0, c1, nreq;
  logic seen;

  initial begin
    e_id  = '{16'h0000, 16'h8000, 16'h0001, 16'h8001};
    e_len = '{16'd1024, 16'd512, 16'd1024, 16'd512};
    e_ch  = '{1'b0, 1'b1, 1'b0, 1'b1};
    ch0_fifo_data = 8'hA5;
    ch1_fifo_data = 8'h5A;

    // reset values
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req",  32'(bus.udp_tx_req), 32'd0);
    chk("rst_len",  32'(bus.udp_send_data_length), 32'd0);
    chk("rst_id",   32'(bus.identify_code), 32'd0);
    chk("rst_act",  32'(active_ch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_errs", 32'({len_err, timeout_err}), 32'd0);
    chk("rst_rd",   32'({ch0_fifo_rd_en, ch1_fifo_rd_en}), 32'd0);

    // single channel
    do_reset();
    bus.mac_ready  = 1'b1;
    ch0_enable     = 1'b1;
    ch0_fifo_count = 11'd1024;
    wait_req("s1", w);
    chk("s1_len", 32'(r_len), 32'd1024);
    chk("s1_id",  32'(r_id), 32'h0000);
    chk("s1_ch",  32'(r_ch), 32'd0);
    send_pkt(1024, c0, c1);
    chk("s1_rd0", 32'(c0), 32'd1024);
    chk("s1_rd1", 32'(c1), 32'd0);
    chk("s1_lerr", 32'(len_err), 32'd0);
    wait_req("s2", w);
    chk("s2_id", 32'(r_id), 32'h0001);
    send_pkt(1024, c0, c1);

    // round robin
    do_reset();
    bus.mac_ready  = 1'b1;
    ch0_enable     = 1'b1;
    ch1_enable     = 1'b1;
    ch0_fifo_count = 11'd1024;
    ch1_fifo_count = 11'd512;
    for (int k = 0; k < 4; k++) begin
      wait_req("rr", w);
      if (k > 0) chk("rr_gap", 32'(w + 1), 32'(IFG + 2));
      chk("rr_ch",  32'(r_ch), 32'(e_ch[k]));
      chk("rr_id",  32'(r_id), 32'(e_id[k]));
      chk("rr_len", 32'(r_len), 32'(e_len[k]));
      send_pkt(int'(e_len[k]), c0, c1);
      chk("rr_rd", 32'(e_ch[k] ? c1 : c0), 32'(e_len[k]));
      chk("rr_rdx", 32'(e_ch[k] ? c0 : c1), 32'd0);
    end

    // threshold edge
    do_reset();
    bus.mac_ready  = 1'b1;
    ch1_enable     = 1'b1;
    ch1_fifo_count = 11'd511;
    nreq = 0;
    repeat (20) begin
      @(negedge clk);
      nreq += int'(bus.udp_tx_req);
    end
    chk("thr_511", 32'(nreq), 32'd0);
    ch1_fifo_count = 11'd512;
    @(negedge clk);
    chk("thr_c1", 32'(bus.udp_tx_req), 32'd0);
    @(negedge clk);
    chk("thr_c2", 32'(bus.udp_tx_req), 32'd1);
    chk("thr_id", 32'(bus.identify_code), 32'h8000);
    r_ch = 1'b1;
    send_pkt(512, c0, c1);
    chk("thr_rd1", 32'(c1), 32'd512);

    // short packet
    do_reset();
    bus.mac_ready  = 1'b1;
    ch0_enable     = 1'b1;
    ch0_fifo_count = 11'd1024;
    wait_req("le", w);
    send_pkt(1000, c0, c1);
    chk("le_err", 32'(len_err), 32'd1);
    wait_req("le2", w);
    chk("le_seq", 32'(r_id), 32'h0001);
    chk("le_sticky", 32'(len_err), 32'd1);

    // watchdog (short-timeout instance)
    do_reset();
    ch0_enable     = 1'b1;
    ch0_fifo_count = 11'd1024;
    bus2.mac_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus2.udp_tx_req) seen = 1'b1;
    end
    chk("to_req", 32'(seen), 32'd1);
    chk("to_id0", 32'(bus2.identify_code), 32'h0000);
    repeat (TO) @(negedge clk);
    chk("to_early", 32'(t_to_err), 32'd0);
    @(negedge clk);
    chk("to_fire", 32'(t_to_err), 32'd1);
    chk("to_gap", 32'(t_busy), 32'd1);
    repeat (IFG) @(negedge clk);
    chk("to_arb", 32'(t_busy), 32'd0);
    @(negedge clk);
    chk("to_req2", 32'(bus2.udp_tx_req), 32'd1);
    chk("to_seq", 32'(bus2.identify_code), 32'h0000);
    chk("to_lerr", 32'(t_len_err), 32'd0);
    bus2.mac_ready = 1'b0;

    // mac_ready drop mid-packet
    do_reset();
    bus.mac_ready  = 1'b1;
    ch0_enable     = 1'b1;
    ch0_fifo_count = 11'd1024;
    wait_req("md", w);
    bus.mac_ready = 1'b0;
    send_pkt(1024, c0, c1);
    chk("md_rd0", 32'(c0), 32'd1024);
    chk("md_lerr", 32'(len_err), 32'd0);
    nreq = 0;
    repeat (60) begin
      @(negedge clk);
      nreq += int'(bus.udp_tx_req);
    end
    chk("md_noreq", 32'(nreq), 32'd0);
    chk("md_idle", 32'(busy), 32'd0);
    bus.mac_ready = 1'b1;
    wait_req("md2", w);
    chk("md_id", 32'(r_id), 32'h0001);

    // async reset mid-SEND
    @(negedge clk);
    bus.mac_fifo_rd_en = 1'b1;
    #1;
    chk("ar_pre", 32'(ch0_fifo_rd_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_rd", 32'({ch0_fifo_rd_en, ch1_fifo_rd_en}), 32'd0);
    chk("ar_id", 32'(bus.identify_code), 32'd0);
    chk("ar_len", 32'(bus.udp_send_data_length), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    bus.mac_fifo_rd_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_req("ar2", w);
    chk("ar_id2", 32'(r_id), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
